// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - CPU trace capture FSM with halt detection and FWFT trace FIFO
module cpu_trace_monitor #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int NWATCH      = 1,
    parameter int HALT_CYCLES = 4,
    parameter int MODE        = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       en,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            iaddr,
    input  logic [NWATCH*XLEN-1:0]     watch,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_iaddr,
    output logic [NWATCH*XLEN-1:0]     rd_watch,
    output logic [31:0]                rd_cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       halted,
    output logic [31:0]                retired
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(HALT_CYCLES) + 1;
    localparam int EW = 2*XLEN + NWATCH*XLEN + 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t           state;
    logic [XLEN-1:0]  pc_prev;
    logic [SW-1:0]    stable_cnt;
    logic [31:0]      cycle_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [EW-1:0]    mem [DEPTH];

    logic             pc_chg;
    logic             active;
    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic [CW-1:0]    count_nxt;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = !empty;
    assign halted   = (state == S_HALTED);
    assign {rd_pc, rd_iaddr, rd_watch, rd_cycle} = mem[rd_ptr];

    // Capture only while RUN with en still asserted; en=0 in RUN is the exit cycle.
    always_comb begin
        pc_chg   = (pc != pc_prev);
        active   = (state == S_RUN) && en;
        push_req = active && ((MODE == 0) || pc_chg);
        pop      = rd_req && !empty;
        push_ok  = push_req && (!full || pop);
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr] <= {pc, iaddr, watch, cycle_cnt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc_prev    <= '0;
            stable_cnt <= '0;
            cycle_cnt  <= '0;
            retired    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            pc_prev <= pc;
            if (clr) begin
                state      <= S_IDLE;
                stable_cnt <= '0;
                cycle_cnt  <= '0;
                retired    <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                count     <= count_nxt;
                if (push_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push_req && full && !pop)
                    overflow <= 1'b1;
                case (state)
                    S_IDLE: begin
                        stable_cnt <= '0;
                        if (en)
                            state <= S_RUN;
                    end
                    S_RUN: begin
                        if (!en) begin
                            state      <= S_IDLE;
                            stable_cnt <= '0;
                        end else if (pc_chg) begin
                            stable_cnt <= '0;
                            if (retired != 32'hFFFF_FFFF)
                                retired <= retired + 32'd1;
                        end else if (stable_cnt == SW'(HALT_CYCLES-1)) begin
                            state      <= S_HALTED;
                            stable_cnt <= '0;
                        end else begin
                            stable_cnt <= stable_cnt + SW'(1);
                        end
                    end
                    default: stable_cnt <= '0;
                endcase
            end
        end
    end
endmodule

// File: doc/cpu_trace_monitor.md
CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- XLEN, 32: data width.
- DEPTH, 16: trace entries; power of two, 2 or more.
- NWATCH, 1: watched registers; 1 to 4.
- HALT_CYCLES, 4: consecutive stable-pc cycles that declare halt; 2 or more.
- MODE, 0: 0 = capture every RUN cycle; 1 = capture only on pc change.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: asynchronous active-low reset.
- clr, in, 1: synchronous clear.
- en, in, 1: capture enable.
- pc, in, XLEN: CPU program counter.
- iaddr, in, XLEN: instruction fetch address.
- watch, in, NWATCH*XLEN: watched register values; channel k occupies bits [k*XLEN +: XLEN].
- rd_req, in, 1: pop request.
- rd_valid, out, 1: head entry available.
- rd_pc, out, XLEN: head pc.
- rd_iaddr, out, XLEN: head iaddr.
- rd_watch, out, NWATCH*XLEN: head watch values.
- rd_cycle, out, 32: head timestamp.
- count, out, $clog2(DEPTH)+1: occupancy.
- full, out, 1: full flag.
- empty, out, 1: empty flag.
- overflow, out, 1: sticky drop flag.
- halted, out, 1: CPU halt detected.
- retired, out, 32: pc-change counter.

Function
REQ-004 The block SHALL implement three states:
- IDLE: entered at reset and on clr.
- RUN: entered from IDLE on any edge with en=1.
- HALTED: entered from RUN per REQ-008.
- It SHALL leave HALTED only on clr or reset.
- en=0 in RUN SHALL return the state to IDLE.
REQ-005 pc_prev SHALL register pc on every clock edge in every state.
REQ-006 A sample {pc, iaddr, watch, cycle_cnt} SHALL be pushed only in RUN:
- MODE=0: every cycle.
- MODE=1: only when pc != pc_prev.
REQ-007 retired SHALL increment on each RUN cycle with pc != pc_prev; it SHALL saturate at 32'hFFFF_FFFF.
REQ-008 stable_cnt SHALL behave as follows:
- In RUN, it increments when pc == pc_prev and clears otherwise.
- In IDLE, it clears.
- On an edge where pc == pc_prev and stable_cnt == HALT_CYCLES-1, the state SHALL become HALTED.
- The push for that cycle still occurs.
REQ-009 halted SHALL be 1 exactly while the state is HALTED.
REQ-010 cycle_cnt SHALL be a free-running 32-bit counter that increments every edge, wraps 0xFFFF_FFFF->0, and is cleared by clr.
REQ-011 The trace buffer SHALL be a first-word-fall-through FIFO:
- rd_valid = !empty.
- rd_* SHALL present the head entry with no register stage.
- rd_* SHALL be don't-care when empty.
REQ-012 A pop SHALL occur on an edge with rd_req=1 and rd_valid=1; rd_req while empty SHALL be ignored.
REQ-013 A push while full without a simultaneous pop SHALL be dropped and SHALL set overflow, which stays set until clr or reset.
REQ-014 A simultaneous push and pop while full SHALL accept both, keep count unchanged, and leave overflow unchanged.
REQ-015 A simultaneous push and pop while empty SHALL accept the push only; count becomes 1.
REQ-016 full SHALL be (count == DEPTH) and empty SHALL be (count == 0); read and write pointers SHALL wrap modulo DEPTH.
REQ-017 clr SHALL take priority over all same-cycle events and SHALL:
- empty the FIFO;
- zero retired, stable_cnt, cycle_cnt and overflow;
- force IDLE.

Reset
REQ-018 While reset=0, the block SHALL immediately set:
- state to IDLE;
- count, pointers, pc_prev, stable_cnt, cycle_cnt and retired to 0;
- empty to 1;
- full, overflow, halted and rd_valid to 0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries; capture SHALL not resume until en=1 is sampled after reset is released.

Verification
Parameters for all scenarios: DEPTH=4, HALT_CYCLES=3, NWATCH=1, MODE=0 unless stated.
REQ-020 Reset, then en=1, pc=0,4,8 on consecutive cycles, no reads -> count=3, retired=2 (0->4, 4->8), head rd_pc=0, then 4, then 8 on successive pops.
REQ-021 en=1 for 6 cycles, no reads -> full=1 after the 4th push, overflow=1 after the 5th, and the head still holds the first sample.
REQ-022 FIFO full, rd_req=1 while pushing for 3 cycles -> count stays 4, overflow stays 0, popped rd_pc values are in push order.
REQ-023 pc held at 0x20 from RUN entry -> halted=1 after 3 consecutive equal comparisons, pushes stop, and halted stays 1 with en=1 until clr pulses, after which the state is IDLE and count=0.
REQ-024 MODE=1, pc sequence 0,0,4,4,4,8 -> only the pc=4 and pc=8 samples are pushed; halted=0 because the run of equal comparisons is 2, not 3.
REQ-025 Reset pulsed low for 3 ns mid-RUN with count=2 -> count=0, empty=1 and rd_valid=0 asynchronously; no push until en=1 is sampled after release.
